// File: rtl/elevator_call_scheduler.sv
// elevator_call_scheduler
// Latches hall/car calls and drives one car floor by floor in collective
// (SCAN) order, then sequences the door dwell. A lock mode parks the car
// with the door closed and the call latch cleared.
//
// Ports:
//   clk           rising-edge clock
//   reset         asynchronous, active-high
//   call_req      one request bit per floor (pulse or level)
//   hold          keeps the door open while high in DOOR
//   lock          requests lock mode (taken only from IDLE)
//   current_floor registered floor index
//   moving        high while travelling (MOVE)
//   dir_up        travel direction, 1 = up
//   door_open     high during the door dwell (DOOR)
//   locked        high while parked in LOCKED
//   pending       latched outstanding calls
module elevator_call_scheduler #(
  parameter  int FLOORS        = 4,
  parameter  int TRAVEL_CYCLES = 8,
  parameter  int DOOR_CYCLES   = 4,
  localparam int FW            = $clog2(FLOORS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [FLOORS-1:0] call_req,
  input  logic              hold,
  input  logic              lock,
  output logic [FW-1:0]     current_floor,
  output logic              moving,
  output logic              dir_up,
  output logic              door_open,
  output logic              locked,
  output logic [FLOORS-1:0] pending
);

  // One counter serves both the travel timer and the door dwell timer.
  localparam int CMAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] TRAVEL_LOAD = CW'(TRAVEL_CYCLES - 1);
  localparam logic [CW-1:0] DOOR_LOAD   = CW'(DOOR_CYCLES - 1);
  localparam logic [FW-1:0] TOP         = FW'(FLOORS - 1);

  typedef enum logic [1:0] {IDLE, MOVE, DOOR, LOCKED} state_t;

  state_t            state, state_n;
  logic [FW-1:0]     floor_n, next_floor;
  logic              dir_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [FLOORS-1:0] pend_n;
  logic              above, below, ahead_next, here_call;

  function automatic logic any_above(input logic [FLOORS-1:0] p, input logic [FW-1:0] f);
    any_above = 1'b0;
    for (int i = 0; i < FLOORS; i++)
      if (p[i] && (i > int'(f))) any_above = 1'b1;
  endfunction

  function automatic logic any_below(input logic [FLOORS-1:0] p, input logic [FW-1:0] f);
    any_below = 1'b0;
    for (int i = 0; i < FLOORS; i++)
      if (p[i] && (i < int'(f))) any_below = 1'b1;
  endfunction

  always_comb begin
    state_n   = state;
    floor_n   = current_floor;
    dir_n     = dir_up;
    cnt_n     = cnt;
    pend_n    = pending | call_req;
    here_call = call_req[current_floor];
    above     = any_above(pending, current_floor);
    below     = any_below(pending, current_floor);
    // Saturate at the end floors so the index can never leave the shaft,
    // even if the direction bit and the call pattern ever disagree.
    if (dir_up) next_floor = (current_floor == TOP) ? current_floor : current_floor + FW'(1);
    else        next_floor = (current_floor == '0)  ? current_floor : current_floor - FW'(1);
    ahead_next = dir_up ? any_above(pending, next_floor) : any_below(pending, next_floor);

    unique case (state)
      IDLE: begin
        if (lock) begin
          state_n = LOCKED;
          pend_n  = '0;
        end else if (pending[current_floor]) begin
          state_n                = DOOR;
          cnt_n                  = DOOR_LOAD;
          pend_n[current_floor]  = 1'b0;
        end else if ((dir_up && above) || (!dir_up && !below && above)) begin
          state_n = MOVE;
          dir_n   = 1'b1;
          cnt_n   = TRAVEL_LOAD;
        end else if ((!dir_up && below) || (dir_up && !above && below)) begin
          state_n = MOVE;
          dir_n   = 1'b0;
          cnt_n   = TRAVEL_LOAD;
        end
      end
      MOVE: begin
        if (cnt == '0) begin
          floor_n = next_floor;
          if (pending[next_floor]) begin
            state_n            = DOOR;
            cnt_n              = DOOR_LOAD;
            pend_n[next_floor] = 1'b0;
          end else if (ahead_next) begin
            cnt_n = TRAVEL_LOAD;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      DOOR: begin
        // A call for the open floor only stretches the dwell; it is never latched.
        pend_n[current_floor] = 1'b0;
        if (hold || here_call) cnt_n = DOOR_LOAD;
        else if (cnt == '0)    state_n = IDLE;
        else                   cnt_n = cnt - CW'(1);
      end
      LOCKED: begin
        pend_n = '0;
        if (!lock) state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      current_floor <= '0;
      dir_up        <= 1'b1;
      cnt           <= '0;
      pending       <= '0;
      moving        <= 1'b0;
      door_open     <= 1'b0;
      locked        <= 1'b0;
    end else begin
      state         <= state_n;
      current_floor <= floor_n;
      dir_up        <= dir_n;
      cnt           <= cnt_n;
      pending       <= pend_n;
      moving        <= (state_n == MOVE);
      door_open     <= (state_n == DOOR);
      locked        <= (state_n == LOCKED);
    end
  end

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Scoreboard bench for elevator_call_scheduler (defaults: 4 floors,
// 8-cycle travel, 4-cycle dwell). Stimulus pushes the expected output
// tuple for a given edge number; the monitor samples on the falling edge
// and compares whatever is due.
module tb_elevator_call_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] call_req;
  logic       hold, lock;
  logic [1:0] current_floor;
  logic       moving, dir_up, door_open, locked;
  logic [3:0] pending;

  elevator_call_scheduler dut (
    .clk(clk), .reset(rst), .call_req(call_req), .hold(hold), .lock(lock),
    .current_floor(current_floor), .moving(moving), .dir_up(dir_up),
    .door_open(door_open), .locked(locked), .pending(pending)
  );

  always #5 clk = ~clk;

  int ecnt   = 0;
  int n_chk  = 0;
  int n_pass = 0;

  // expected {floor, moving, dir_up, door_open, locked, pending}
  int         eq[$];
  logic [9:0] vq[$];
  string      nq[$];

  initial forever begin
    @(posedge clk);
    ecnt++;
  end

  initial forever begin
    @(negedge clk);
    while (eq.size() > 0 && eq[0] <= ecnt) begin
      int         e;
      logic [9:0] v, a;
      string      nm;
      e  = eq.pop_front();
      v  = vq.pop_front();
      nm = nq.pop_front();
      a  = {current_floor, moving, dir_up, door_open, locked, pending};
      n_chk++;
      if (e != ecnt)
        $display("FAIL %s: check for edge %0d missed (now edge %0d)", nm, e, ecnt);
      else if (a !== v)
        $display("FAIL %s: edge %0d got fl=%0d mv=%b up=%b door=%b lk=%b pend=%b, want fl=%0d mv=%b up=%b door=%b lk=%b pend=%b",
                 nm, e, a[9:8], a[7], a[6], a[5], a[4], a[3:0], v[9:8], v[7], v[6], v[5], v[4], v[3:0]);
      else
        n_pass++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, %0d/%0d so far", n_pass, n_chk);
    $fatal(1);
  end

  task automatic ex(input int e, input logic [1:0] f, input logic mv, input logic du,
                    input logic dr, input logic lk, input logic [3:0] pd, input string nm);
    eq.push_back(e);
    vq.push_back({f, mv, du, dr, lk, pd});
    nq.push_back(nm);
  endtask

  // Returns just after edge e; inputs driven now are sampled at edge e+1.
  task automatic wait_to(input int e);
    if (ecnt < e) begin
      while (ecnt < e) begin
        @(posedge clk);
        #1;
      end
      #1;
    end
  endtask

  task automatic do_reset();
    call_req = '0; hold = 1'b0; lock = 1'b0;
    rst = 1'b1;
    wait_to(ecnt + 2);
    rst = 1'b0;
  endtask

  // Call to floor 2 from reset; edge numbers relative to reset release.
  task automatic single_call(input string tag);
    int b;
    b = ecnt;
    ex(b + 0,  2'd0, 0, 1, 0, 0, 4'b0000, {tag, "_reset"});
    ex(b + 1,  2'd0, 0, 1, 0, 0, 4'b0100, {tag, "_latch"});
    ex(b + 2,  2'd0, 1, 1, 0, 0, 4'b0100, {tag, "_start"});
    ex(b + 9,  2'd0, 1, 1, 0, 0, 4'b0100, {tag, "_pre_f1"});
    ex(b + 10, 2'd1, 1, 1, 0, 0, 4'b0100, {tag, "_f1"});
    ex(b + 17, 2'd1, 1, 1, 0, 0, 4'b0100, {tag, "_pre_f2"});
    ex(b + 18, 2'd2, 0, 1, 1, 0, 4'b0000, {tag, "_arrive"});
    ex(b + 21, 2'd2, 0, 1, 1, 0, 4'b0000, {tag, "_dwell_end"});
    ex(b + 22, 2'd2, 0, 1, 0, 0, 4'b0000, {tag, "_idle"});
    call_req = 4'b0100;
    wait_to(b + 1);
    call_req = '0;
    wait_to(b + 22);
  endtask

  initial begin
    int b;
    rst = 1'b1; call_req = '0; hold = 1'b0; lock = 1'b0;

    // Single call
    wait_to(2);
    rst = 1'b0;
    single_call("single");
    wait_to(ecnt + 1);

    // SCAN: heading up past floor 1 with calls at 0 and 3
    do_reset();
    b = ecnt;
    ex(b + 1,  2'd0, 0, 1, 0, 0, 4'b1000, "scan_latch");
    ex(b + 10, 2'd1, 1, 1, 0, 0, 4'b1000, "scan_f1");
    ex(b + 12, 2'd1, 1, 1, 0, 0, 4'b1001, "scan_both");
    ex(b + 18, 2'd2, 1, 1, 0, 0, 4'b1001, "scan_pass_f2");
    ex(b + 26, 2'd3, 0, 1, 1, 0, 4'b0001, "scan_stop3");
    ex(b + 29, 2'd3, 0, 1, 1, 0, 4'b0001, "scan_door3_end");
    ex(b + 30, 2'd3, 0, 1, 0, 0, 4'b0001, "scan_idle3");
    ex(b + 31, 2'd3, 1, 0, 0, 0, 4'b0001, "scan_reverse");
    ex(b + 39, 2'd2, 1, 0, 0, 0, 4'b0001, "scan_down_f2");
    ex(b + 55, 2'd0, 0, 0, 1, 0, 4'b0000, "scan_stop0");
    ex(b + 59, 2'd0, 0, 0, 0, 0, 4'b0000, "scan_idle0");
    call_req = 4'b1000;
    wait_to(b + 1);
    call_req = '0;
    wait_to(b + 11);
    call_req = 4'b1001;
    wait_to(b + 12);
    call_req = '0;
    wait_to(b + 60);

    // Hold, same-floor call, lock in IDLE, lock during travel
    do_reset();
    b = ecnt;
    ex(b + 18, 2'd2, 0, 1, 1, 0, 4'b0000, "hold_arrive");
    ex(b + 28, 2'd2, 0, 1, 1, 0, 4'b0000, "hold_last");
    ex(b + 31, 2'd2, 0, 1, 1, 0, 4'b0000, "hold_tail");
    ex(b + 32, 2'd2, 0, 1, 0, 0, 4'b0000, "hold_close");
    ex(b + 33, 2'd2, 0, 1, 0, 0, 4'b0100, "here_latch");
    ex(b + 34, 2'd2, 0, 1, 1, 0, 4'b0000, "here_open");
    ex(b + 35, 2'd2, 0, 1, 1, 0, 4'b0000, "here_not_latched");
    ex(b + 38, 2'd2, 0, 1, 1, 0, 4'b0000, "here_extended");
    ex(b + 39, 2'd2, 0, 1, 0, 0, 4'b0000, "here_close");
    ex(b + 40, 2'd2, 0, 1, 0, 0, 4'b1000, "lock_pending");
    ex(b + 41, 2'd2, 0, 1, 0, 1, 4'b0000, "lock_enter");
    ex(b + 43, 2'd2, 0, 1, 0, 1, 4'b0000, "lock_ignore_call");
    ex(b + 44, 2'd2, 0, 1, 0, 1, 4'b0000, "lock_hold");
    ex(b + 45, 2'd2, 0, 1, 0, 0, 4'b0000, "lock_exit");
    ex(b + 46, 2'd2, 0, 1, 0, 0, 4'b0000, "lock_idle");
    ex(b + 47, 2'd2, 0, 1, 0, 0, 4'b1000, "lmove_latch");
    ex(b + 50, 2'd2, 1, 1, 0, 0, 4'b1000, "lmove_ignored");
    ex(b + 56, 2'd3, 0, 1, 1, 0, 4'b0000, "lmove_door");
    ex(b + 60, 2'd3, 0, 1, 0, 0, 4'b0000, "lmove_idle");
    ex(b + 61, 2'd3, 0, 1, 0, 1, 4'b0000, "lmove_locked");
    ex(b + 62, 2'd3, 0, 1, 0, 0, 4'b0000, "lmove_unlock");
    call_req = 4'b0100;
    wait_to(b + 1);  call_req = '0;
    wait_to(b + 18); hold = 1'b1;
    wait_to(b + 28); hold = 1'b0;
    wait_to(b + 32); call_req = 4'b0100;
    wait_to(b + 33); call_req = '0;
    wait_to(b + 34); call_req = 4'b0100;
    wait_to(b + 35); call_req = '0;
    wait_to(b + 39); call_req = 4'b1000;
    wait_to(b + 40); call_req = 4'b0010; lock = 1'b1;
    wait_to(b + 41); call_req = 4'b0001;
    wait_to(b + 43); call_req = '0;
    wait_to(b + 44); lock = 1'b0;
    wait_to(b + 46); call_req = 4'b1000;
    wait_to(b + 47); call_req = '0;
    wait_to(b + 49); lock = 1'b1;
    wait_to(b + 61); lock = 1'b0;
    wait_to(b + 63);

    // Reset halfway between floors 1 and 2, then a normal single call
    do_reset();
    b = ecnt;
    ex(b + 1,  2'd0, 0, 1, 0, 0, 4'b1000, "rmid_latch");
    ex(b + 2,  2'd0, 1, 1, 0, 0, 4'b1000, "rmid_start");
    ex(b + 13, 2'd1, 1, 1, 0, 0, 4'b1000, "rmid_travel");
    ex(b + 14, 2'd0, 0, 1, 0, 0, 4'b0000, "rmid_async_reset");
    call_req = 4'b1000;
    wait_to(b + 1);  call_req = '0;
    wait_to(b + 14); rst = 1'b1;
    wait_to(b + 16); rst = 1'b0;
    single_call("after_reset");
    wait_to(ecnt + 2);

    if (eq.size() != 0) begin
      n_chk++;
      $display("FAIL drain: %0d expected entries never checked, want 0", eq.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/elevator_call_scheduler.md
# elevator_call_scheduler

Multi-floor call scheduler sitting above the per-car floor outputs in the elevator designs. It latches hall/car call requests and moves one car floor by floor with a travel timer. Requests are served in collective (SCAN) order: the car continues in its current direction while calls remain ahead. It also sequences the door-open dwell (extendable by hold) and a lock mode that parks the car with the door closed.

## Interface
- FLOORS, 4: number of floors, 2..8; floors numbered 0..FLOORS-1.
- TRAVEL_CYCLES, 8: clock cycles to move one floor, ≥1.
- DOOR_CYCLES, 4: minimum door-open dwell in cycles, ≥1.
- FW, $clog2(FLOORS): floor index width (derived, not overridden).

- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high; all state to reset values.
- call_req  in  FLOORS  one bit per floor; sampled every edge, may be pulse or level.
- hold  in  1  level; while high in DOOR, dwell counter is reloaded.
- lock  in  1  level; requests lock mode.
- current_floor  out  FW  registered floor index; reset 0.
- moving  out  1  high in MOVE; reset 0.
- dir_up  out  1  travel direction, 1 = up; reset 1.
- door_open  out  1  high in DOOR; reset 0.
- locked  out  1  high in LOCKED; reset 0.
- pending  out  FLOORS  latched outstanding calls; reset 0.

## Operation
- States: IDLE, MOVE, DOOR, LOCKED; reset to IDLE. All outputs are registered.
- Call latch:
  - Every edge outside LOCKED: pending |= call_req.
  - The bit for current_floor is cleared on entry to DOOR. A call for current_floor while in DOOR reloads the dwell counter and is not latched.
- Decisions use registered pending only. A call accepted at edge N influences decisions from edge N+1.
- above = any pending bit > current_floor; below = any pending bit < current_floor.
- IDLE, priority order:
  - lock → LOCKED.
  - pending[current_floor] → DOOR.
  - (dir_up and above) or (!dir_up and !below and above) → MOVE, dir_up=1.
  - (!dir_up and below) or (dir_up and !above and below) → MOVE, dir_up=0.
  - Otherwise stay in IDLE.
- MOVE:
  - Travel counter is loaded with TRAVEL_CYCLES-1 on entry and decrements each cycle.
  - At the edge where the counter is 0: current_floor ±1 per dir_up, then evaluate at the new floor.
  - If the new floor's pending bit is set → DOOR. Else if calls remain ahead in dir_up → stay in MOVE and reload the counter. Else → IDLE.
  - Direction never changes while in MOVE. current_floor never leaves 0..FLOORS-1.
- DOOR:
  - Dwell counter is loaded with DOOR_CYCLES-1 on entry and decrements each cycle.
  - hold, or call_req[current_floor], reloads it to DOOR_CYCLES-1.
  - At the edge where the counter is 0 with no reload → IDLE.
- LOCKED:
  - pending is cleared on entry and call_req is ignored.
  - door_open=0, moving=0.
  - Exit to IDLE at the first edge where lock=0.
- lock is honoured only from IDLE. In MOVE/DOOR it takes effect once the car next returns to IDLE.
- Reset mid-MOVE or mid-DOOR: immediate return to reset values. current_floor=0 regardless of physical position; resynchronisation is upstream's job.

## Timing
- Call to motion: a call_req pulse sampled at edge N sets pending at N. IDLE→MOVE at N+1, so moving=1 after edge N+1.
- Per-floor travel: exactly TRAVEL_CYCLES cycles between current_floor updates.
- Arrival to door: door_open rises at the same edge that updates current_floor.
- Dwell: door_open is high for exactly DOOR_CYCLES cycles without hold; each hold or same-floor call cycle extends it.
- After DOOR expires, IDLE lasts at least one cycle before the next MOVE.
- Simultaneous calls above and below: the current dir_up direction wins; the opposite side is served on the reversal.
- lock and call_req in the same IDLE cycle: lock wins and pending is cleared.

## Test plan
- Single call, defaults: reset, then call_req=4'b0100 for one cycle (sampled at edge 1).
  - moving=1 after edge 2; current_floor=1 at edge 10 and 2 at edge 18.
  - door_open high for edges 18-22; pending=0 from edge 18; IDLE after edge 22.
- SCAN order: car at floor 1 moving up; calls 0 and 3 latched together.
  - Car stops at 3 first (door 4 cycles), then reverses and stops at 0. dir_up=0 during the descent.
- Hold: at floor 2 in DOOR, hold high for 10 cycles → door_open stays high until DOOR_CYCLES cycles after hold falls.
- Lock: lock=1 in IDLE with pending=4'b1000 → locked=1 next edge, pending=0; call_req is ignored while locked; lock=0 → IDLE, locked=0.
- Lock during travel: lock raised mid-MOVE toward floor 3 → the car completes its stop and door dwell, then enters LOCKED.
- Reset mid-MOVE: assert reset at floor 1 halfway through a move → all outputs return to reset values asynchronously; the first call after release behaves as in the single-call scenario.
